// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front end: loader state enum, frame geometry
// and the address bit-reversal helper.
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        PRESENT,
        WAIT_ACK
    } state_t;

    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned ADDR_W    = 2;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/flash_frame_loader.sv
// Loads four stream samples into the flash register store, then presents and holds a frame.
// Define FLASH_FRAME_LOADER_BITREV_EN to write samples in bit-reversed address order.
module flash_frame_loader
    import fft_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_ena,
    output logic [ADDR_W-1:0] o_address,
    output logic [N-1:0]      o_word,
    output logic              o_frame_valid,
    input  logic              i_frame_ack,
    output logic [CNT_W-1:0]  o_frame_cnt,
    output logic              o_busy
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_ready;
    logic                r_ena;
    logic [ADDR_W-1:0]   r_address;
    logic [N-1:0]        r_word;
    logic                r_frame_valid;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic                r_busy;

    logic [ADDR_W-1:0]   w_map;
    logic                w_accept;

`ifdef FLASH_FRAME_LOADER_BITREV_EN
    assign w_map = bitrev(r_idx);
`else
    assign w_map = r_idx;
`endif

    assign w_accept = i_valid & r_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= LOAD;
            r_idx         <= '0;
            r_ready       <= 1'b1;
            r_ena         <= 1'b0;
            r_address     <= '0;
            r_word        <= '0;
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_ena <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_ena     <= 1'b1;
                        r_address <= w_map;
                        r_word    <= i_data;
                        r_idx     <= r_idx + 1'b1;
                        if (r_idx == ADDR_W'(FRAME_LEN - 1)) begin
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= SETTLE;
                        end
                    end
                end
                // Store registers the last write at the end of this cycle.
                SETTLE: begin
                    r_state <= PRESENT;
                end
                PRESENT: begin
                    r_frame_valid <= 1'b1;
                    r_state       <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (i_frame_ack) begin
                        r_frame_valid <= 1'b0;
                        r_frame_cnt   <= r_frame_cnt + 1'b1;
                        r_ready       <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= LOAD;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign o_ready       = r_ready;
    assign o_ena         = r_ena;
    assign o_address     = r_address;
    assign o_word        = r_word;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_flash_frame_loader.sv
// Directed bench for flash_frame_loader with a behavioural 4-word store and a CNT_W=2 twin.
module tb_flash_frame_loader;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic        valid;
    logic        ack;

    logic        ready, ena, fv, busy;
    logic [1:0]  addr;
    logic [15:0] word;
    logic [7:0]  cnt;

    logic        ready2, ena2, fv2, busy2;
    logic [1:0]  addr2;
    logic [15:0] word2;
    logic [1:0]  cnt2;

    logic [15:0] store [4];

    int checks = 0;
    int errors = 0;

    flash_frame_loader #(.N(16), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(ready),
        .o_ena(ena), .o_address(addr), .o_word(word), .o_frame_valid(fv),
        .i_frame_ack(ack), .o_frame_cnt(cnt), .o_busy(busy)
    );

    flash_frame_loader #(.N(16), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(ready2),
        .o_ena(ena2), .o_address(addr2), .o_word(word2), .o_frame_valid(fv2),
        .i_frame_ack(ack), .o_frame_cnt(cnt2), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ena) store[addr] <= word;
    end

    function automatic logic [1:0] emap(input int k);
        logic [1:0] v;
        v = k[1:0];
`ifdef FLASH_FRAME_LOADER_BITREV_EN
        return {v[0], v[1]};
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_ena"},   32'(ena),   32'd0);
        chk({tag, "_addr"},  32'(addr),  32'd0);
        chk({tag, "_word"},  32'(word),  32'd0);
        chk({tag, "_fv"},    32'(fv),    32'd0);
        chk({tag, "_cnt"},   32'(cnt),   32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
    endtask

    // Back-to-back frame with ack in the first WAIT_ACK cycle.
    task automatic run_frame(input logic [15:0] base, input logic [7:0] exp_cnt,
                             input logic [1:0] exp_cnt2);
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data = base + 16'(k);
            step();
            chk("frm_addr", 32'(addr), 32'(emap(k)));
        end
        valid = 1'b0;
        step();
        step();
        chk("frm_fv", 32'(fv), 32'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("frm_cnt",  32'(cnt),  32'(exp_cnt));
        chk("frm_cnt2", 32'(cnt2), 32'(exp_cnt2));
    endtask

    logic [15:0] d4 [4];

    initial begin
        rst   = 1'b1;
        data  = '0;
        valid = 1'b0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        #3 rst = 1'b0;
        step();

        // Streaming frame with i_valid held high throughout.
        d4[0] = 16'h0011; d4[1] = 16'h0022; d4[2] = 16'h0033; d4[3] = 16'h0044;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data = d4[k];
            step();
            chk("s_ena",  32'(ena),  32'd1);
            chk("s_addr", 32'(addr), 32'(emap(k)));
            chk("s_word", 32'(word), 32'(d4[k]));
            chk("s_ready", 32'(ready), (k == 3) ? 32'd0 : 32'd1);
        end
        chk("s_busy", 32'(busy), 32'd1);
        data = 16'h0055;
        step();
        chk("s_t1_ena", 32'(ena), 32'd0);
        chk("s_t1_fv",  32'(fv),  32'd0);
        step();
        chk("s_t2_fv",  32'(fv),  32'd1);
        for (int k = 0; k < 4; k++) chk("s_store", 32'(store[emap(k)]), 32'(d4[k]));

        // Frame held with ack low; valid stays high but is refused.
        for (int k = 0; k < 10; k++) begin
            step();
            chk("h_fv",    32'(fv),    32'd1);
            chk("h_ready", 32'(ready), 32'd0);
            chk("h_ena",   32'(ena),   32'd0);
        end
        valid = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("a_fv",    32'(fv),    32'd0);
        chk("a_cnt",   32'(cnt),   32'd1);
        chk("a_ready", 32'(ready), 32'd1);
        chk("a_busy",  32'(busy),  32'd0);
        chk("a_store", 32'(store[emap(0)]), 32'h0011);

        // Gapped stream; ack held from the last accept on must not count before fv rises.
        d4[0] = 16'h0101; d4[1] = 16'h0202; d4[2] = 16'h0303; d4[3] = 16'h0404;
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1;
            data = d4[k];
            step();
            chk("g_ena",  32'(ena),  32'd1);
            chk("g_addr", 32'(addr), 32'(emap(k)));
            chk("g_word", 32'(word), 32'(d4[k]));
            valid = 1'b0;
            if (k == 3) ack = 1'b1;
            step();
            chk("g_gap_ena", 32'(ena), 32'd0);
        end
        chk("g_t1_fv", 32'(fv), 32'd0);
        step();
        chk("g_t2_fv",  32'(fv),  32'd1);
        chk("g_t2_cnt", 32'(cnt), 32'd1);
        for (int k = 0; k < 4; k++) chk("g_store", 32'(store[emap(k)]), 32'(d4[k]));
        step();
        ack = 1'b0;
        chk("g_t3_fv",    32'(fv),    32'd0);
        chk("g_t3_cnt",   32'(cnt),   32'd2);
        chk("g_t3_ready", 32'(ready), 32'd1);

        // Reset after two accepts discards the partial frame.
        valid = 1'b1;
        data = 16'hAAAA;
        step();
        chk("r_ena_a", 32'(ena), 32'd1);
        data = 16'hBBBB;
        step();
        chk("r_addr_b", 32'(addr), 32'(emap(1)));
        #1 rst = 1'b1;
        #1;
        chk_reset_vals("async");
        valid = 1'b0;
        #1 rst = 1'b0;
        step();
        d4[0] = 16'h00C1; d4[1] = 16'h00C2; d4[2] = 16'h00C3; d4[3] = 16'h00C4;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data = d4[k];
            step();
            chk("rr_addr", 32'(addr), 32'(emap(k)));
            chk("rr_word", 32'(word), 32'(d4[k]));
        end
        valid = 1'b0;
        step();
        step();
        chk("rr_fv",  32'(fv),  32'd1);
        chk("rr_cnt", 32'(cnt), 32'd0);
        for (int k = 0; k < 4; k++) chk("rr_store", 32'(store[emap(k)]), 32'(d4[k]));
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("rr_cnt1", 32'(cnt), 32'd1);

        // Counter wrap on the CNT_W=2 instance, starting from reset.
        rst = 1'b1;
        #2 rst = 1'b0;
        step();
        run_frame(16'h0001, 8'd1, 2'd1);
`ifdef FLASH_FRAME_LOADER_BITREV_EN
        chk("bo_store0", 32'(store[0]), 32'h1);
        chk("bo_store1", 32'(store[1]), 32'h3);
        chk("bo_store2", 32'(store[2]), 32'h2);
        chk("bo_store3", 32'(store[3]), 32'h4);
`else
        chk("bo_store0", 32'(store[0]), 32'h1);
        chk("bo_store1", 32'(store[1]), 32'h2);
        chk("bo_store2", 32'(store[2]), 32'h3);
        chk("bo_store3", 32'(store[3]), 32'h4);
`endif
        run_frame(16'h0010, 8'd2, 2'd2);
        run_frame(16'h0020, 8'd3, 2'd3);
        run_frame(16'h0030, 8'd4, 2'd0);
        run_frame(16'h0040, 8'd5, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
